// File: rtl/ws_dmem_pkg.sv
// Shared types and constants for the wait-stated data memory.
package ws_mem_pkg;

    // Access width encoding, as presented on the size port
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    // Width of the completed-write signature counter
    localparam int WR_COUNT_W = 16;

endpackage

// File: rtl/ws_dmem_if.sv
// Request/response bundle between a core data port and ws_dmem.
interface ws_dmem_if #(
    parameter int AW = 32
) ();

    logic                             req;
    logic                             we;
    logic [1:0]                       size;
    logic [AW-1:0]                    a;
    logic [31:0]                      wd;
    logic                             ready;
    logic [31:0]                      rd;
    logic                             err;
    logic [ws_mem_pkg::WR_COUNT_W-1:0] wr_count;

    modport master (
        output req, we, size, a, wd,
        input  ready, rd, err, wr_count
    );

    modport slave (
        input  req, we, size, a, wd,
        output ready, rd, err, wr_count
    );

endinterface

// File: rtl/ws_dmem_align.sv
// Little-endian lane steering and alignment checking for one access.
module ws_mem_align
    import ws_mem_pkg::*;
(
    input  size_t       i_size,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wd,
    input  logic [31:0] i_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    // Replicate write data onto every candidate lane and pick the lanes to touch
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = 32'd0;
        o_rdata    = 32'd0;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wd[7:0]}};
                case (i_addr)
                    2'd0:    o_rdata = {24'd0, i_word[7:0]};
                    2'd1:    o_rdata = {24'd0, i_word[15:8]};
                    2'd2:    o_rdata = {24'd0, i_word[23:16]};
                    default: o_rdata = {24'd0, i_word[31:24]};
                endcase
            end
            SZ_HALF: begin
                o_misalign = i_addr[0];
                o_be       = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wd[15:0]}};
                o_rdata    = i_addr[1] ? {16'd0, i_word[31:16]} : {16'd0, i_word[15:0]};
            end
            SZ_WORD: begin
                o_misalign = |i_addr;
                o_be       = 4'b1111;
                o_wdata    = i_wd;
                o_rdata    = i_word;
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
        if (o_misalign) begin
            o_be = 4'b0000;
        end
    end

endmodule

// File: rtl/ws_dmem.sv
// Wait-stated word-organised data memory with byte/half/word access,
// error reporting and a wrapping completed-write counter.
// AW must exceed $clog2(DEPTH)+2 so an out-of-range field exists.
module ws_dmem
    import ws_mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2,
    parameter int AW    = 32
) (
    input  logic     clk,
    input  logic     reset,
    ws_dmem_if.slave bus
);

    localparam int IDXW = $clog2(DEPTH);

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_we;
    size_t                 r_size;
    logic [AW-1:0]         r_addr;
    logic [31:0]           r_wd;
    logic [31:0]           r_rd;
    logic                  r_err;
    logic [WR_COUNT_W-1:0] r_wr_count;
    logic [31:0]           r_mem [DEPTH];

    logic [IDXW-1:0]       w_idx;
    logic                  w_oob;
    logic                  w_misalign;
    logic                  w_err;
    logic                  w_accept;
    logic                  w_fire;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rdata;
    logic [31:0]           w_word;

    assign w_idx    = r_addr[IDXW+1:2];
    assign w_oob    = |r_addr[AW-1:IDXW+2];
    assign w_word   = r_mem[w_idx];
    assign w_err    = w_misalign | w_oob;
    assign w_accept = (r_state == IDLE) && bus.req;
    assign w_fire   = (r_state == BUSY) && (r_cnt == 4'd0);

    assign bus.ready    = (r_state == RESP);
    assign bus.rd       = r_rd;
    assign bus.err      = r_err;
    assign bus.wr_count = r_wr_count;

    ws_mem_align u_align (
        .i_size     (r_size),
        .i_addr     (r_addr[1:0]),
        .i_wd       (r_wd),
        .i_word     (w_word),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign)
    );

    // State register; reset drops an in-flight access and any pending ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state: requests only count in IDLE, RESP always lasts one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req) w_next = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Wait counter loads at acceptance and counts down through BUSY
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'(WAIT);
        end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture the request so the requester may drop it after acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we   <= 1'b0;
            r_size <= SZ_BYTE;
            r_addr <= '0;
            r_wd   <= 32'd0;
        end else if (w_accept) begin
            r_we   <= bus.we;
            r_size <= size_t'(bus.size);
            r_addr <= bus.a;
            r_wd   <= bus.wd;
        end
    end

    // Completion results; writes and rejected accesses return zero read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd       <= 32'd0;
            r_err      <= 1'b0;
            r_wr_count <= '0;
        end else if (w_fire) begin
            r_err <= w_err;
            r_rd  <= (w_err || r_we) ? 32'd0 : w_rdata;
            if (r_we && !w_err) begin
                r_wr_count <= r_wr_count + WR_COUNT_W'(1);
            end
        end
    end

    // Storage array, updated lane by lane on a successful write completion
    always_ff @(posedge clk) begin
        if (w_fire && r_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ws_dmem.sv
// Directed scoreboard bench for ws_dmem: one WAIT=2 instance for the main
// sequence and one WAIT=0 instance for zero-wait latency and counter wrap.
module tb_ws_dmem;
    import ws_mem_pkg::*;

    typedef struct {
        logic        expErr;
        logic [31:0] expRd;
        logic        chkRd;
        logic [15:0] expWc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst0_n;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] wc2         = 16'd0;
    logic [15:0] wc0         = 16'd0;
    exp_t        sb[$];

    ws_dmem_if #(.AW(32)) bus2 ();
    ws_dmem_if #(.AW(32)) bus0 ();

    ws_dmem #(.DEPTH(64), .WAIT(2), .AW(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus2.slave)
    );

    ws_dmem #(.DEPTH(64), .WAIT(0), .AW(32)) dut0 (
        .clk   (clk),
        .reset (rst0_n),
        .bus   (bus0.slave)
    );

    // 10 ns free-running clock
    always #5 clk = ~clk;

    // One counted comparison
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one request into an idle DUT, hold it for the accepting edge, push expectation
    task automatic applyStimulus(input bit sel, input logic we, input logic [1:0] size,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic bad, input logic [31:0] expRd);
        exp_t e;
        if (we && !bad) begin
            if (sel) wc0 = wc0 + 16'd1;
            else     wc2 = wc2 + 16'd1;
        end
        e.expErr = bad;
        e.chkRd  = !we;
        e.expRd  = bad ? 32'd0 : expRd;
        e.expWc  = sel ? wc0 : wc2;
        if (sel) begin
            bus0.req = 1'b1; bus0.we = we; bus0.size = size; bus0.a = a; bus0.wd = wd;
        end else begin
            bus2.req = 1'b1; bus2.we = we; bus2.size = size; bus2.a = a; bus2.wd = wd;
        end
        @(posedge clk);
        #1;
        if (sel) bus0.req = 1'b0;
        else     bus2.req = 1'b0;
        sb.push_back(e);
    endtask

    // Wait (bounded) for ready, check latency, pop and compare, confirm single-cycle pulse
    task automatic checkOutput(input string tag, input bit sel, input int waitv);
        int   k;
        logic rdy;
        exp_t e;
        k   = 0;
        rdy = 1'b0;
        while (!rdy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            rdy = sel ? bus0.ready : bus2.ready;
        end
        check32({tag, " latency"}, 32'(k), 32'(waitv + 1));
        e = sb.pop_front();
        check32({tag, " err"}, {31'd0, sel ? bus0.err : bus2.err}, {31'd0, e.expErr});
        if (e.chkRd || e.expErr) begin
            check32({tag, " rd"}, sel ? bus0.rd : bus2.rd, e.expRd);
        end
        check32({tag, " wr_count"}, {16'd0, sel ? bus0.wr_count : bus2.wr_count}, {16'd0, e.expWc});
        @(posedge clk);
        #1;
        check32({tag, " pulse"}, {31'd0, sel ? bus0.ready : bus2.ready}, 32'd0);
    endtask

    initial begin
        int   edgeN;
        int   lastEdge;
        int   nReady;
        int   consec;
        logic prevReady;
        logic sawReady;
        exp_t e;

        bus2.req = 1'b0; bus2.we = 1'b0; bus2.size = 2'b00; bus2.a = 32'd0; bus2.wd = 32'd0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.size = 2'b00; bus0.a = 32'd0; bus0.wd = 32'd0;
        rst_n  = 1'b0;
        rst0_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset ready", {31'd0, bus2.ready}, 32'd0);
        check32("reset err", {31'd0, bus2.err}, 32'd0);
        check32("reset rd", bus2.rd, 32'd0);
        check32("reset wr_count", {16'd0, bus2.wr_count}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst0_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic word/byte/half traffic, WAIT=2");
        applyStimulus(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 32'd0);  checkOutput("wr word 0x10", 0, 2);
        applyStimulus(0, 0, 2'b10, 32'h10, 32'd0, 0, 32'hDEADBEEF);  checkOutput("rd word 0x10", 0, 2);
        applyStimulus(0, 1, 2'b00, 32'h13, 32'h0000005A, 0, 32'd0);  checkOutput("wr byte 0x13", 0, 2);
        applyStimulus(0, 0, 2'b10, 32'h10, 32'd0, 0, 32'h5AADBEEF);  checkOutput("rd word merged", 0, 2);
        applyStimulus(0, 0, 2'b01, 32'h12, 32'd0, 0, 32'h00005AAD);  checkOutput("rd half 0x12", 0, 2);
        applyStimulus(0, 0, 2'b00, 32'h11, 32'd0, 0, 32'h000000BE);  checkOutput("rd byte 0x11", 0, 2);
        applyStimulus(0, 1, 2'b10, 32'h14, 32'h00000000, 0, 32'd0);  checkOutput("wr word 0x14", 0, 2);
        applyStimulus(0, 1, 2'b01, 32'h16, 32'hFFFF1234, 0, 32'd0);  checkOutput("wr half 0x16", 0, 2);
        applyStimulus(0, 1, 2'b00, 32'h15, 32'hFFFFFFA5, 0, 32'd0);  checkOutput("wr byte 0x15", 0, 2);
        applyStimulus(0, 0, 2'b10, 32'h14, 32'd0, 0, 32'h1234A500);  checkOutput("rd word 0x14", 0, 2);
        applyStimulus(0, 0, 2'b01, 32'h14, 32'd0, 0, 32'h0000A500);  checkOutput("rd half 0x14", 0, 2);

        $display("[TB] rejected accesses");
        applyStimulus(0, 1, 2'b01, 32'h11, 32'h0000FFFF, 1, 32'd0);  checkOutput("err half odd", 0, 2);
        applyStimulus(0, 0, 2'b10, 32'h02, 32'd0, 1, 32'd0);         checkOutput("err word 0x02", 0, 2);
        applyStimulus(0, 1, 2'b11, 32'h10, 32'h99999999, 1, 32'd0);  checkOutput("err size 11", 0, 2);
        applyStimulus(0, 1, 2'b10, 32'h100, 32'h77777777, 1, 32'd0); checkOutput("err out of range", 0, 2);
        applyStimulus(0, 0, 2'b10, 32'h10, 32'd0, 0, 32'h5AADBEEF);  checkOutput("rd after errors", 0, 2);

        $display("[TB] reset during BUSY");
        applyStimulus(0, 1, 2'b10, 32'h20, 32'h22222222, 0, 32'd0);  checkOutput("wr 0x22222222", 0, 2);
        applyStimulus(0, 0, 2'b10, 32'h10, 32'd0, 0, 32'h5AADBEEF);  checkOutput("rd before abort", 0, 2);
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.size = 2'b10; bus2.a = 32'h20; bus2.wd = 32'h11111111;
        @(posedge clk);
        #1;
        bus2.req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        wc2   = 16'd0;
        #1;
        check32("abort ready", {31'd0, bus2.ready}, 32'd0);
        check32("abort err", {31'd0, bus2.err}, 32'd0);
        check32("abort rd", bus2.rd, 32'd0);
        check32("abort wr_count", {16'd0, bus2.wr_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sawReady = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            sawReady = sawReady | bus2.ready;
        end
        check32("abort no ready", {31'd0, sawReady}, 32'd0);
        applyStimulus(0, 0, 2'b10, 32'h20, 32'd0, 0, 32'h22222222);  checkOutput("rd after abort", 0, 2);

        $display("[TB] reset during RESP");
        applyStimulus(0, 0, 2'b10, 32'h20, 32'd0, 0, 32'h22222222);
        sawReady = 1'b0;
        for (int k = 0; k < 40 && !sawReady; k++) begin
            @(posedge clk);
            #1;
            sawReady = bus2.ready;
        end
        e = sb.pop_front();
        check32("resp ready seen", {31'd0, sawReady}, 32'd1);
        check32("resp rd", bus2.rd, e.expRd);
        #2;
        rst_n = 1'b0;
        #1;
        check32("resp async drop", {31'd0, bus2.ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] request held high for 10 accesses");
        for (int i = 0; i < 10; i++) begin
            e.expErr = 1'b0; e.expRd = 32'h22222222; e.chkRd = 1'b1; e.expWc = 16'd0;
            sb.push_back(e);
        end
        bus2.req = 1'b1; bus2.we = 1'b0; bus2.size = 2'b10; bus2.a = 32'h20; bus2.wd = 32'd0;
        edgeN = 0; lastEdge = 0; nReady = 0; consec = 0; prevReady = 1'b0;
        while (nReady < 10 && edgeN < 80) begin
            @(posedge clk);
            #1;
            edgeN++;
            if (bus2.ready) begin
                nReady++;
                if (prevReady) consec++;
                if (nReady > 1) check32("stream spacing", 32'(edgeN - lastEdge), 32'd5);
                lastEdge = edgeN;
                e = sb.pop_front();
                check32("stream rd", bus2.rd, e.expRd);
                if (nReady == 10) bus2.req = 1'b0;
            end
            prevReady = bus2.ready;
        end
        bus2.req = 1'b0;
        check32("stream count", 32'(nReady), 32'd10);
        check32("stream consecutive", 32'(consec), 32'd0);
        sawReady = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            sawReady = sawReady | bus2.ready;
        end
        check32("stream stops", {31'd0, sawReady}, 32'd0);

        $display("[TB] WAIT=0 latency and counter wrap");
        applyStimulus(1, 1, 2'b10, 32'h00, 32'hCAFEF00D, 0, 32'd0);  checkOutput("w0 wr word", 1, 0);
        applyStimulus(1, 0, 2'b00, 32'h03, 32'd0, 0, 32'h000000CA);  checkOutput("w0 rd byte", 1, 0);
        force dut0.r_wr_count = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut0.r_wr_count;
        wc0 = 16'hFFFE;
        @(posedge clk);
        #1;
        check32("w0 preset", {16'd0, bus0.wr_count}, 32'h0000FFFE);
        applyStimulus(1, 1, 2'b10, 32'h04, 32'h01010101, 0, 32'd0);  checkOutput("w0 to FFFF", 1, 0);
        applyStimulus(1, 1, 2'b10, 32'h08, 32'h02020202, 0, 32'd0);  checkOutput("w0 wrap", 1, 0);
        applyStimulus(1, 1, 2'b01, 32'h101, 32'h0, 1, 32'd0);        checkOutput("w0 err", 1, 0);
        applyStimulus(1, 0, 2'b10, 32'h08, 32'd0, 0, 32'h02020202);  checkOutput("w0 rd word", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
